switch_lock_seq: RTL and testbench
==================================

// Module: switch_lock_seq
// PURPOSE
//  Parametrised switch-lock sequencer. Drives lock_enb for a bounded window and then one done pulse.
//  Each accepted switch_enb request gets one window.
//  A wrap transition (select all-ones -> all-zeros) gets a delayed, long window; any other transition
//  gets an immediate, short window. Sits in front of the switch fabric, which samples lock_enb/done.
// PARAMETERS
//  SEL_W      2   width of switch_select; wrap = prev all-ones, current all-zeros
//  SHORT_MAX  2   max lock_enb cycles, non-wrap request (>=1)
//  LONG_MAX   10  max lock_enb cycles, wrap request (>=SHORT_MAX)
//  LEN_W      derived localparam = $clog2(LONG_MAX+1); not overridable
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous, active-high reset
//  switch_enb     in   1      request strobe, sampled every clk
//  switch_select  in   SEL_W  requested switch position
//  lock_len       in   LEN_W  requested lock length, clamped (see BEHAVIOUR)
//  busy           out  1      high in ARM, LOCK and DONE states
//  lock_enb       out  1      lock window active
//  done           out  1      single-cycle end-of-window pulse
//  wrap_seen      out  1      registered; 1 = current window is a wrap window
//  req_drop       out  1      1-cycle pulse: switch_enb arrived while busy, request ignored
// BEHAVIOUR
//  Reset (rst=1 at posedge): all outputs 0, prev_sel=0, counters 0, state=IDLE. Reset beats every other event.
//  prev_sel: registers switch_select on every clock, independent of state.
//  wrap = (switch_select=='0) && (prev_sel=='1), evaluated in the request cycle.
//  FSM states: IDLE, ARM, LOCK, DONE.
//   IDLE + switch_enb, non-wrap: latch len -> LOCK; lock_enb=1 from cycle t+1.
//   IDLE + switch_enb, wrap: latch len -> ARM; ARM lasts 1 cycle, then LOCK; lock_enb=1 from cycle t+2.
//   LOCK: lock_enb=1 for exactly len cycles, then DONE.
//   DONE: done=1 and lock_enb=0 for 1 cycle, then IDLE.
//  Clamp rule: len = max(1, min(lock_len, wrap ? LONG_MAX : SHORT_MAX)). lock_len=0 gives len=1.
//  Request to done latency:
//   non-wrap: done at t+len+1.
//   wrap: done at t+len+2.
//  wrap_seen: set on entry to ARM; cleared on exit from DONE.
//  Busy rule: switch_enb is ignored while busy=1. req_drop=1 on the next cycle; state and len are unaffected.
//  Back-to-back: a request in the DONE cycle is dropped. A request in the first IDLE cycle is accepted.
//  lock_enb and done are never high together. done is never high for 2 consecutive cycles.
//  Reset mid-window: lock_enb/done drop to 0 the cycle after the reset edge. No done is emitted for the aborted window.
//  All outputs are registered (no combinational input-to-output paths).
// TESTING
//  1. rst 3 cycles, idle -> all outputs 0; busy=0; prev_sel=0.
//  2. sel 01->10, switch_enb at t, lock_len=2 -> lock_enb t+1..t+2, done t+3, wrap_seen=0.
//  3. sel 11->00, switch_enb at t, lock_len=10 -> ARM t+1, lock_enb t+2..t+11, done t+12, wrap_seen=1.
//  4. Clamp: non-wrap lock_len=9 -> 2 lock cycles. Wrap lock_len=0 -> 1 lock cycle, done at t+3.
//  5. switch_enb at t+1 and in the DONE cycle of test 2 -> req_drop pulses; window unchanged. Request at t+4 accepted.
//  6. rst at 5th lock cycle of wrap window -> lock_enb=0 next cycle; no done; prev_sel=0 (next 00 is non-wrap).

Source files
------------

// File: rtl/switch_lock_seq.sv
// switch_lock_seq: drives lock_enb for one bounded window per accepted
// switch_enb request, then a single done pulse. A wrap transition of the
// switch position (all-ones -> all-zeros) gets a one-cycle arming delay and
// the long length cap; any other transition locks immediately with the short cap.
module switch_lock_seq #(
   parameter int unsigned SEL_W     = 2,
   parameter int unsigned SHORT_MAX = 2,
   parameter int unsigned LONG_MAX  = 10,
   localparam int unsigned LEN_W    = $clog2(LONG_MAX + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             switch_enb,
   input  logic [SEL_W-1:0] switch_select,
   input  logic [LEN_W-1:0] lock_len,
   output logic             busy,
   output logic             lock_enb,
   output logic             done,
   output logic             wrap_seen,
   output logic             req_drop
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      LOCK = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [LEN_W-1:0] SHORT_CAP = LEN_W'(SHORT_MAX);
   localparam logic [LEN_W-1:0] LONG_CAP  = LEN_W'(LONG_MAX);
   localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

   state_t           state;
   state_t           state_nx;
   logic [SEL_W-1:0] prev_sel;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] cnt_nx;
   logic             wrap_seen_nx;
   logic             req_drop_nx;
   logic             wrap;
   logic [LEN_W-1:0] len_cap;
   logic [LEN_W-1:0] len_min;
   logic [LEN_W-1:0] req_len;

   // Wrap detection and request length clamp, evaluated in the request cycle
   always_comb begin
      wrap    = (switch_select == '0) && (prev_sel == '1);
      len_cap = wrap ? LONG_CAP : SHORT_CAP;
      len_min = (lock_len > len_cap) ? len_cap : lock_len;
      req_len = (len_min == '0) ? LEN_ONE : len_min;
   end

   // Next-state, window counter and registered-output decode
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      wrap_seen_nx = wrap_seen;
      req_drop_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (switch_enb) begin
               cnt_nx = req_len;
               if (wrap) begin
                  state_nx     = ARM;
                  wrap_seen_nx = 1'b1;
               end else begin
                  state_nx = LOCK;
               end
            end
         end
         ARM: begin
            state_nx = LOCK;
         end
         LOCK: begin
            if (cnt <= LEN_ONE) begin
               state_nx = DONE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt - LEN_ONE;
            end
         end
         DONE: begin
            state_nx     = IDLE;
            wrap_seen_nx = 1'b0;
         end
         default: begin
            state_nx     = IDLE;
            cnt_nx       = '0;
            wrap_seen_nx = 1'b0;
         end
      endcase
      // Requests arriving mid-window are ignored and flagged one cycle later
      if ((state != IDLE) && switch_enb) begin
         req_drop_nx = 1'b1;
      end
   end

   // State, counter, previous select and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         prev_sel  <= '0;
         busy      <= 1'b0;
         lock_enb  <= 1'b0;
         done      <= 1'b0;
         wrap_seen <= 1'b0;
         req_drop  <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         prev_sel  <= switch_select;
         busy      <= (state_nx != IDLE);
         lock_enb  <= (state_nx == LOCK);
         done      <= (state_nx == DONE);
         wrap_seen <= wrap_seen_nx;
         req_drop  <= req_drop_nx;
      end
   end

endmodule

// File: tb/tb_switch_lock_seq.sv
// Directed self-checking bench for switch_lock_seq (default parameters).
module tb_switch_lock_seq;

   localparam int unsigned SEL_W = 2;
   localparam int unsigned LEN_W = 4;

   logic             clk;
   logic             rst;
   logic             switch_enb;
   logic [SEL_W-1:0] switch_select;
   logic [LEN_W-1:0] lock_len;
   logic             busy;
   logic             lock_enb;
   logic             done;
   logic             wrap_seen;
   logic             req_drop;
   logic [4:0]       outs;
   logic             done_q;

   int n_checks;
   int n_pass;

   switch_lock_seq dut (
      .clk           (clk),
      .rst           (rst),
      .switch_enb    (switch_enb),
      .switch_select (switch_select),
      .lock_len      (lock_len),
      .busy          (busy),
      .lock_enb      (lock_enb),
      .done          (done),
      .wrap_seen     (wrap_seen),
      .req_drop      (req_drop)
   );

   // {busy, lock_enb, done, wrap_seen, req_drop}
   assign outs = {busy, lock_enb, done, wrap_seen, req_drop};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic expect_outs(input string tag, input logic [4:0] exp);
      check(tag, 32'(outs), 32'(exp));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One request from idle: psel primes prev_sel, sel is the request position
   task automatic run_window(input logic [1:0] psel, input logic [1:0] sel,
                             input logic [3:0] len, input logic w, input int n);
      switch_select = psel;
      tick();
      switch_select = sel;
      lock_len      = len;
      switch_enb    = 1'b1;
      tick();
      switch_enb = 1'b0;
      if (w) begin
         expect_outs("arm", 5'b10010);
         tick();
      end
      for (int i = 0; i < n; i++) begin
         expect_outs("lock", {1'b1, 1'b1, 1'b0, w, 1'b0});
         tick();
      end
      expect_outs("done", {1'b1, 1'b0, 1'b1, w, 1'b0});
      tick();
      expect_outs("idle_after", 5'b00000);
   endtask

   // Output invariants every cycle
   always @(negedge clk) begin
      check("lock_done_excl", 32'(lock_enb & done), 32'd0);
      check("done_repeat", 32'(done & done_q), 32'd0);
      done_q = done;
   end

   initial begin
      n_checks      = 0;
      n_pass        = 0;
      done_q        = 1'b0;
      rst           = 1'b1;
      switch_enb    = 1'b0;
      switch_select = 2'b00;
      lock_len      = 4'd0;

      // Reset and idle
      repeat (3) tick();
      expect_outs("reset", 5'b00000);
      rst = 1'b0;
      tick();
      expect_outs("idle", 5'b00000);

      // Basic non-wrap and wrap windows, clamps and wrap-detection boundaries
      run_window(2'b01, 2'b10, 4'd2,  1'b0, 2);
      run_window(2'b11, 2'b00, 4'd10, 1'b1, 10);
      run_window(2'b00, 2'b00, 4'd9,  1'b0, 2);
      run_window(2'b11, 2'b00, 4'd0,  1'b1, 1);
      run_window(2'b10, 2'b11, 4'd0,  1'b0, 1);
      run_window(2'b11, 2'b00, 4'd15, 1'b1, 10);
      run_window(2'b11, 2'b01, 4'd1,  1'b0, 1);
      run_window(2'b01, 2'b00, 4'd5,  1'b0, 2);
      run_window(2'b11, 2'b00, 4'd7,  1'b1, 7);

      // Dropped requests while busy, then back-to-back accept
      switch_select = 2'b01;
      tick();
      switch_select = 2'b10;
      lock_len      = 4'd2;
      switch_enb    = 1'b1;
      tick();
      expect_outs("b2b_t1", 5'b11000);
      tick();
      expect_outs("b2b_t2_drop", 5'b11001);
      switch_enb = 1'b0;
      tick();
      expect_outs("b2b_t3_done", 5'b10100);
      switch_enb = 1'b1;
      tick();
      expect_outs("b2b_t4_drop", 5'b00001);
      tick();
      switch_enb = 1'b0;
      expect_outs("b2b_t5", 5'b11000);
      tick();
      expect_outs("b2b_t6", 5'b11000);
      tick();
      expect_outs("b2b_t7_done", 5'b10100);
      tick();
      expect_outs("b2b_t8", 5'b00000);

      // Reset during the fifth lock cycle of a wrap window
      switch_select = 2'b11;
      tick();
      switch_select = 2'b00;
      lock_len      = 4'd10;
      switch_enb    = 1'b1;
      tick();
      switch_enb = 1'b0;
      expect_outs("abort_arm", 5'b10010);
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_outs("abort_lock", 5'b11010);
      end
      rst           = 1'b1;
      switch_select = 2'b11;
      tick();
      expect_outs("abort_reset", 5'b00000);
      rst           = 1'b0;
      switch_select = 2'b00;
      lock_len      = 4'd1;
      switch_enb    = 1'b1;
      tick();
      switch_enb = 1'b0;
      expect_outs("post_reset_nonwrap", 5'b11000);
      tick();
      expect_outs("post_reset_done", 5'b10100);
      tick();
      expect_outs("post_reset_idle", 5'b00000);
      tick();
      expect_outs("post_reset_quiet", 5'b00000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Absolute time bound
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
